// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: drives the GPR write port one cycle after capture, owns HI/LO/LLbit
// with same-cycle bypass, and counts retired instructions. Stall/flush controls gate the capture.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              mem_valid,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  input  logic              mem_llbit_we,
  input  logic              mem_llbit_val,
  output logic              wb_wreg,
  output logic [ADDR_W-1:0] wb_wd,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              llbit_o,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef struct packed {
    logic              valid;
    logic              wreg;
    logic [ADDR_W-1:0] wd;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              llbit_we;
    logic              llbit_val;
  } pipe_t;

  pipe_t             pipe_q;
  pipe_t             pipe_cap;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              llbit_q;

  // A bubble from MEM must never commit side effects, whatever its payload says.
  always_comb begin
    pipe_cap           = '0;
    pipe_cap.valid     = mem_valid;
    pipe_cap.wreg      = mem_valid & mem_wreg;
    pipe_cap.wd        = mem_wd;
    pipe_cap.wdata     = mem_wdata;
    pipe_cap.whilo     = mem_valid & mem_whilo;
    pipe_cap.hi        = mem_hi;
    pipe_cap.lo        = mem_lo;
    pipe_cap.llbit_we  = mem_valid & mem_llbit_we;
    pipe_cap.llbit_val = mem_llbit_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      llbit_q    <= 1'b0;
      retire_cnt <= '0;
    end else begin
      if (flush) begin
        pipe_q <= '0;
      end else if (stall_mem && !stall_wb) begin
        pipe_q <= '0;
      end else if (!stall_mem) begin
        pipe_q <= pipe_cap;
      end

      // A flushed instruction has not retired, so its HI/LO result is dropped.
      if (pipe_q.whilo && !flush) begin
        hi_q <= pipe_q.hi;
        lo_q <= pipe_q.lo;
      end

      if (flush) begin
        llbit_q <= 1'b0;
      end else if (pipe_q.llbit_we) begin
        llbit_q <= pipe_q.llbit_val;
      end

      if (!flush && !stall_mem && mem_valid) begin
        retire_cnt <= retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign wb_wreg  = pipe_q.valid & pipe_q.wreg;
  assign wb_wd    = pipe_q.wd;
  assign wb_wdata = pipe_q.wdata;

  assign hi_o    = pipe_q.whilo ? pipe_q.hi : hi_q;
  assign lo_o    = pipe_q.whilo ? pipe_q.lo : lo_q;
  assign llbit_o = flush ? 1'b0 : (pipe_q.llbit_we ? pipe_q.llbit_val : llbit_q);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, hand sequences for flush/reset corners,
// and randomized traffic checked against a cycle-level reference model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, stall_mem, stall_wb, mem_valid, mem_wreg;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_whilo, mem_llbit_we, mem_llbit_val;

  logic        wb_wreg, llbit_o;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata, hi_o, lo_o, retire_cnt;

  logic        w_wreg, w_llbit;
  logic [4:0]  w_wd;
  logic [31:0] w_wdata, w_hi, w_lo;
  logic [3:0]  w_cnt;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_mem(stall_mem), .stall_wb(stall_wb),
    .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_llbit_we(mem_llbit_we), .mem_llbit_val(mem_llbit_val),
    .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
    .hi_o(hi_o), .lo_o(lo_o), .llbit_o(llbit_o), .retire_cnt(retire_cnt)
  );

  // Narrow counter instance so wraparound is reached quickly.
  mem_wb_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) u_wrap (
    .clk(clk), .rst(rst), .flush(flush), .stall_mem(stall_mem), .stall_wb(stall_wb),
    .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_llbit_we(mem_llbit_we), .mem_llbit_val(mem_llbit_val),
    .wb_wreg(w_wreg), .wb_wd(w_wd), .wb_wdata(w_wdata),
    .hi_o(w_hi), .lo_o(w_lo), .llbit_o(w_llbit), .retire_cnt(w_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    flush = 0; stall_mem = 0; stall_wb = 0; mem_valid = 0; mem_wreg = 0; mem_wd = 0;
    mem_wdata = 0; mem_whilo = 0; mem_hi = 0; mem_lo = 0; mem_llbit_we = 0; mem_llbit_val = 0;
  endtask

  task automatic check_outs(input string tag, input logic e_wr, input logic [4:0] e_wd,
                            input logic [31:0] e_wdat, input logic [31:0] e_hi,
                            input logic [31:0] e_lo, input logic e_ll, input logic [31:0] e_cnt);
    logic [31:0] c;
    c = e_cnt;
    chk({tag, ".wb_wreg"}, 64'(wb_wreg), 64'(e_wr));
    chk({tag, ".wb_wd"}, 64'(wb_wd), 64'(e_wd));
    chk({tag, ".wb_wdata"}, 64'(wb_wdata), 64'(e_wdat));
    chk({tag, ".hi_o"}, 64'(hi_o), 64'(e_hi));
    chk({tag, ".lo_o"}, 64'(lo_o), 64'(e_lo));
    chk({tag, ".llbit_o"}, 64'(llbit_o), 64'(e_ll));
    chk({tag, ".retire_cnt"}, 64'(retire_cnt), 64'(c));
    chk({tag, ".retire_cnt4"}, 64'(w_cnt), 64'(c[3:0]));
  endtask

  typedef struct {
    logic sm, sw, v, wr; logic [4:0] wd; logic [31:0] wdat;
    logic wh; logic [31:0] hi, lo; logic lwe, lval;
    logic e_wr; logic [4:0] e_wd; logic [31:0] e_wdat, e_hi, e_lo; logic e_ll; logic [31:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic sm, sw, v, wr, input logic [4:0] wd, input logic [31:0] wdat,
                              input logic wh, input logic [31:0] hi, lo, input logic lwe, lval,
                              input logic e_wr, input logic [4:0] e_wd, input logic [31:0] e_wdat,
                              input logic [31:0] e_hi, e_lo, input logic e_ll, input logic [31:0] e_cnt);
    vec_t r;
    r.sm = sm; r.sw = sw; r.v = v; r.wr = wr; r.wd = wd; r.wdat = wdat; r.wh = wh; r.hi = hi;
    r.lo = lo; r.lwe = lwe; r.lval = lval; r.e_wr = e_wr; r.e_wd = e_wd; r.e_wdat = e_wdat;
    r.e_hi = e_hi; r.e_lo = e_lo; r.e_ll = e_ll; r.e_cnt = e_cnt;
    return r;
  endfunction

  // Reference model: the WB-visible record, architectural HI/LO/LLbit, and a retire count.
  typedef struct {
    logic wreg; logic [4:0] wd; logic [31:0] wdata;
    logic whilo; logic [31:0] hi, lo; logic llwe, llval;
  } rec_t;

  rec_t        m_wb;
  logic [31:0] m_hi, m_lo;
  logic        m_ll;
  logic [31:0] m_cnt;

  function automatic rec_t empty_rec();
    rec_t r;
    r.wreg = 0; r.wd = 0; r.wdata = 0; r.whilo = 0; r.hi = 0; r.lo = 0; r.llwe = 0; r.llval = 0;
    return r;
  endfunction

  task automatic model_edge();
    rec_t nxt;
    nxt = m_wb;
    if (flush || (stall_mem && !stall_wb)) begin
      nxt = empty_rec();
    end else if (!stall_mem) begin
      nxt.wreg = mem_valid && mem_wreg; nxt.wd = mem_wd; nxt.wdata = mem_wdata;
      nxt.whilo = mem_valid && mem_whilo; nxt.hi = mem_hi; nxt.lo = mem_lo;
      nxt.llwe = mem_valid && mem_llbit_we; nxt.llval = mem_llbit_val;
    end
    if (m_wb.whilo && !flush) begin
      m_hi = m_wb.hi; m_lo = m_wb.lo;
    end
    if (flush) m_ll = 0;
    else if (m_wb.llwe) m_ll = m_wb.llval;
    if (!flush && !stall_mem && mem_valid) m_cnt = m_cnt + 1;
    m_wb = nxt;
  endtask

  vec_t vecs[12];

  initial begin
    rst = 0;
    idle();
    #2;
    check_outs("reset_async", 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("reset_idle", 0, 0, 0, 0, 0, 0, 0);

    vecs[0]  = mk(0,0,0,0, 0, 0,          0, 0, 0, 0,0,  0, 0, 0,          0,    0,    0, 0);
    vecs[1]  = mk(0,0,1,1, 5, 32'hDEADBEEF,0, 0, 0, 0,0,  1, 5, 32'hDEADBEEF,0,    0,    0, 1);
    vecs[2]  = mk(0,0,1,0, 0, 0,          1, 32'h11,32'h22,0,0, 0,0,0,       32'h11,32'h22,0, 2);
    vecs[3]  = mk(0,0,0,0, 0, 0,          0, 0, 0, 0,0,  0, 0, 0,          32'h11,32'h22,0, 2);
    vecs[4]  = mk(0,0,1,1, 7, 32'h1234,   0, 0, 0, 0,0,  1, 7, 32'h1234,   32'h11,32'h22,0, 3);
    vecs[5]  = mk(1,0,1,1, 9, 32'h99,     0, 0, 0, 0,0,  0, 0, 0,          32'h11,32'h22,0, 3);
    vecs[6]  = mk(0,0,1,1, 10,32'hAA,     0, 0, 0, 0,0,  1, 10,32'hAA,     32'h11,32'h22,0, 4);
    vecs[7]  = mk(1,1,1,1, 11,32'hBB,     0, 0, 0, 0,0,  1, 10,32'hAA,     32'h11,32'h22,0, 4);
    vecs[8]  = mk(0,0,0,1, 12,32'hCC,     1, 32'h55,32'h66,1,1, 0,12,32'hCC, 32'h11,32'h22,0, 4);
    vecs[9]  = mk(0,0,1,1, 3, 32'h1,      0, 0, 0, 1,1,  1, 3, 32'h1,      32'h11,32'h22,1, 5);
    vecs[10] = mk(0,0,0,0, 0, 0,          0, 0, 0, 0,0,  0, 0, 0,          32'h11,32'h22,1, 5);
    vecs[11] = mk(0,0,1,0, 0, 0,          1, 32'h77,32'h88,0,0, 0,0,0,       32'h77,32'h88,1, 6);

    for (int i = 0; i < 12; i++) begin
      stall_mem = vecs[i].sm; stall_wb = vecs[i].sw; mem_valid = vecs[i].v; mem_wreg = vecs[i].wr;
      mem_wd = vecs[i].wd; mem_wdata = vecs[i].wdat; mem_whilo = vecs[i].wh; mem_hi = vecs[i].hi;
      mem_lo = vecs[i].lo; mem_llbit_we = vecs[i].lwe; mem_llbit_val = vecs[i].lval;
      @(posedge clk);
      #1 idle();
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].e_wr, vecs[i].e_wd, vecs[i].e_wdat,
                 vecs[i].e_hi, vecs[i].e_lo, vecs[i].e_ll, vecs[i].e_cnt);
    end

    // Flush against a pending HI/LO commit and a same-cycle SC.
    flush = 1; mem_valid = 1; mem_wreg = 1; mem_wd = 4; mem_llbit_we = 1; mem_llbit_val = 1;
    #1;
    chk("flush_llbit_comb", 64'(llbit_o), 64'd0);
    chk("flush_hi_bypass", 64'(hi_o), 64'h77);
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    check_outs("flush_after", 0, 0, 0, 32'h11, 32'h22, 0, 6);

    // Flush while both stages are stalled still clears the pipe.
    mem_valid = 1; mem_wreg = 1; mem_wd = 6; mem_wdata = 32'h66;
    @(posedge clk);
    #1 idle();
    flush = 1; stall_mem = 1; stall_wb = 1;
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    check_outs("flush_in_stall", 0, 0, 0, 32'h11, 32'h22, 0, 7);

    // Asynchronous reset in the middle of the low phase.
    mem_valid = 1; mem_wreg = 1; mem_wd = 8; mem_wdata = 32'h88; mem_whilo = 1;
    mem_hi = 32'hA; mem_lo = 32'hB;
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    check_outs("pre_reset", 1, 8, 32'h88, 32'hA, 32'hB, 0, 8);
    #1 rst = 0;
    #1;
    check_outs("mid_reset", 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic against the reference model.
    m_wb = empty_rec(); m_hi = 0; m_lo = 0; m_ll = 0; m_cnt = 0;
    @(posedge clk);
    #1 rst = 1;
    for (int n = 0; n < 700; n++) begin
      flush = ($urandom_range(0, 15) == 0);
      stall_mem = ($urandom_range(0, 3) == 0);
      stall_wb = $urandom_range(0, 1) == 1;
      mem_valid = ($urandom_range(0, 4) != 0);
      mem_wreg = $urandom_range(0, 1) == 1;
      mem_wd = 5'($urandom_range(0, 31));
      mem_wdata = $urandom;
      mem_whilo = ($urandom_range(0, 3) == 0);
      mem_hi = $urandom;
      mem_lo = $urandom;
      mem_llbit_we = ($urandom_range(0, 3) == 0);
      mem_llbit_val = $urandom_range(0, 1) == 1;
      @(negedge clk);
      check_outs($sformatf("rnd%0d", n), m_wb.wreg, m_wb.wd, m_wb.wdata,
                 m_wb.whilo ? m_wb.hi : m_hi, m_wb.whilo ? m_wb.lo : m_lo,
                 flush ? 1'b0 : (m_wb.llwe ? m_wb.llval : m_ll), m_cnt);
      model_edge();
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
